// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_pkg
//  Purpose  : Shared widths, reset level, state encodings and access-length
//             codes for the byte-serial main-RAM controller.
//  Revision : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_WORD_W = 32;

    localparam logic c_RST_LVL = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_LEN_BYTE = 2'b00;
    localparam logic [1:0] c_LEN_HALF = 2'b01;
    localparam logic [1:0] c_LEN_WORD = 2'b11;

    // Code 2'b10 is reserved and falls through to a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            c_LEN_BYTE: len_bytes = 3'd1;
            c_LEN_HALF: len_bytes = 3'd2;
            c_LEN_WORD: len_bytes = 3'd4;
            default:    len_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_if
//  Purpose  : Requester, RAM and cache-fill bus of the main-RAM controller.
//             master = requesters plus RAM read data, slave = controller.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int WORD_W = c_WORD_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [WORD_W-1:0] if_data;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_done;
    logic [WORD_W-1:0] mem_rdata;

    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    logic              fill_replace;
    logic [ADDR_W-1:0] fill_addr;
    logic [WORD_W-1:0] fill_data;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr,
               fill_replace, fill_addr, fill_data
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr,
               fill_replace, fill_addr, fill_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Byte-serial, little-endian main-RAM sequencer shared by IF and
//             MEM (MEM has priority); completed IF reads also fill the I-cache.
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int WORD_W = c_WORD_W
) (
    input  logic     clk,
    input  logic     rst,
    mem_ctrl_if.slave bus
);

    state_t            r_state;
    logic              r_owner_mem;
    logic [2:0]        r_n;
    logic [ADDR_W-1:0] r_base;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_buf;
    logic [2:0]        r_iss;
    logic [2:0]        r_cap;
    logic              r_a_vld;
    logic              r_din_vld;

    logic [ADDR_W-1:0] w_base_i;
    logic [WORD_W-1:0] w_word;
    logic [7:0]        w_wbyte;
    logic              w_last_cap;

    assign w_base_i   = r_base + {{(ADDR_W-3){1'b0}}, r_iss};
    assign w_wbyte    = r_wdata[{r_iss[1:0], 3'b000} +: 8];
    assign w_last_cap = (r_cap == (r_n - 3'd1));

    // Word as it will look once the byte arriving this cycle is placed.
    always_comb begin
        w_word = r_buf;
        w_word[{r_cap[1:0], 3'b000} +: 8] = bus.ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst == c_RST_LVL) begin
            r_state          <= ST_IDLE;
            r_owner_mem      <= 1'b0;
            r_n              <= 3'd0;
            r_base           <= '0;
            r_wdata          <= '0;
            r_buf            <= '0;
            r_iss            <= 3'd0;
            r_cap            <= 3'd0;
            r_a_vld          <= 1'b0;
            r_din_vld        <= 1'b0;
            bus.ram_a        <= '0;
            bus.ram_wr       <= 1'b0;
            bus.ram_dout     <= 8'd0;
            bus.if_done      <= 1'b0;
            bus.if_data      <= '0;
            bus.mem_done     <= 1'b0;
            bus.mem_rdata    <= '0;
            bus.fill_replace <= 1'b0;
            bus.fill_addr    <= '0;
            bus.fill_data    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_buf     <= '0;
                    r_iss     <= 3'd1;
                    r_cap     <= 3'd0;
                    r_din_vld <= 1'b0;
                    if (bus.mem_req) begin
                        r_owner_mem <= 1'b1;
                        r_n         <= len_bytes(bus.mem_len);
                        r_base      <= bus.mem_addr;
                        r_wdata     <= bus.mem_wdata;
                        bus.ram_a   <= bus.mem_addr;
                        r_a_vld     <= ~bus.mem_we;
                        if (bus.mem_we) begin
                            bus.ram_wr   <= 1'b1;
                            bus.ram_dout <= bus.mem_wdata[7:0];
                            r_state      <= ST_WRITE;
                        end else begin
                            r_state      <= ST_READ;
                        end
                    end else if (bus.if_req) begin
                        r_owner_mem <= 1'b0;
                        r_n         <= 3'd4;
                        r_base      <= bus.if_addr;
                        bus.ram_a   <= bus.if_addr;
                        r_a_vld     <= 1'b1;
                        r_state     <= ST_READ;
                    end
                end

                // Issue runs one cycle ahead of capture: RAM data lags its address.
                ST_READ: begin
                    r_din_vld <= r_a_vld;
                    if (r_iss < r_n) begin
                        bus.ram_a <= w_base_i;
                        r_iss     <= r_iss + 3'd1;
                        r_a_vld   <= 1'b1;
                    end else begin
                        bus.ram_a <= '0;
                        r_a_vld   <= 1'b0;
                    end
                    if (r_din_vld) begin
                        r_buf <= w_word;
                        r_cap <= r_cap + 3'd1;
                        if (w_last_cap) begin
                            r_state   <= ST_DONE;
                            r_din_vld <= 1'b0;
                            if (r_owner_mem) begin
                                bus.mem_done  <= 1'b1;
                                bus.mem_rdata <= w_word;
                            end else begin
                                bus.if_done      <= 1'b1;
                                bus.if_data      <= w_word;
                                bus.fill_replace <= 1'b1;
                                bus.fill_addr    <= r_base;
                                bus.fill_data    <= w_word;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (r_iss < r_n) begin
                        bus.ram_wr   <= 1'b1;
                        bus.ram_a    <= w_base_i;
                        bus.ram_dout <= w_wbyte;
                        r_iss        <= r_iss + 3'd1;
                    end else begin
                        bus.ram_wr   <= 1'b0;
                        bus.ram_a    <= '0;
                        bus.ram_dout <= 8'd0;
                        bus.mem_done <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    bus.if_done      <= 1'b0;
                    bus.mem_done     <= 1'b0;
                    bus.fill_replace <= 1'b0;
                    r_state          <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Directed and randomized bench for mem_ctrl against a
//             transaction-level timing and data model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32), .WORD_W(32)) bus();

    mem_ctrl #(.ADDR_W(32), .WORD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, got, exp, edge_n);
        end
    endtask

    // ---------------- RAM (environment) and reference memory ----------------
    logic [7:0] tb_ram  [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] seed_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] tb_rd(input logic [31:0] a);
        if (tb_ram.exists(a)) return tb_ram[a];
        return seed_byte(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return seed_byte(a);
    endfunction
    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        tb_ram[a]  = d;
        ref_mem[a] = d;
    endtask

    always @(posedge clk) begin
        if (bus.ram_wr === 1'b1) tb_ram[bus.ram_a] = bus.ram_dout;
        bus.ram_din <= tb_rd(bus.ram_a);
    end

    // ---------------- transaction-level model ----------------
    bit          started = 0;
    bit          act = 0;
    bit          m_mem, m_we;
    int          m_n, m_t0, m_jd;
    int          next_ok = 0;
    logic [31:0] m_base, m_wdata, m_rword;
    logic [31:0] e_if_data = '0, e_mem_rdata = '0, e_fill_addr = '0, e_fill_data = '0;

    always @(posedge clk) begin
        int j;
        bit take;
        edge_n++;
        j = edge_n - m_t0;
        if (act && m_we && j >= 1 && j <= m_n)
            ref_mem[m_base + 32'(j - 1)] = m_wdata[8*(j-1) +: 8];
        if (act && !m_we && j == m_jd) begin
            if (m_mem) e_mem_rdata = m_rword;
            else begin
                e_if_data   = m_rword;
                e_fill_addr = m_base;
                e_fill_data = m_rword;
            end
        end
        if (act && j == m_jd + 1) act = 0;
        take = 0;
        if (rst === 1'b0) begin
            started = 1; act = 0; next_ok = edge_n + 1;
            e_if_data = '0; e_mem_rdata = '0; e_fill_addr = '0; e_fill_data = '0;
        end else if (started && !act && edge_n >= next_ok) begin
            if (bus.mem_req === 1'b1) begin
                take = 1; m_mem = 1; m_we = bus.mem_we;
                m_n = (bus.mem_len == 2'b00) ? 1 : (bus.mem_len == 2'b01) ? 2 : 4;
                m_base = bus.mem_addr; m_wdata = bus.mem_wdata;
            end else if (bus.if_req === 1'b1) begin
                take = 1; m_mem = 0; m_we = 0; m_n = 4;
                m_base = bus.if_addr; m_wdata = '0;
            end
        end
        if (take) begin
            act = 1; m_t0 = edge_n;
            m_jd = m_we ? m_n : m_n + 1;
            next_ok = edge_n + m_jd + 2;
            m_rword = '0;
            for (int i = 0; i < m_n; i++) m_rword[8*i +: 8] = ref_rd(m_base + 32'(i));
        end
    end

    // Single compare point, mid-cycle.
    always @(negedge clk) begin
        int j;
        logic [31:0] ea;
        logic        ewr;
        logic [7:0]  edo;
        logic [2:0]  edn;
        ea = '0; ewr = 1'b0; edo = 8'd0; edn = 3'b000;
        j = edge_n - m_t0;
        if (started) begin
            if (act) begin
                if (j < m_n) begin
                    ea = m_base + 32'(j);
                    if (m_we) begin ewr = 1'b1; edo = m_wdata[8*j +: 8]; end
                end
                if (j == m_jd) edn = m_mem ? 3'b010 : 3'b101;
            end
            chk("ram_a", bus.ram_a, ea);
            chk("ram_wr_dout", {bus.ram_wr, bus.ram_dout}, {ewr, edo});
            chk("ifdone_memdone_fill", {bus.if_done, bus.mem_done, bus.fill_replace}, edn);
            chk("if_data", bus.if_data, e_if_data);
            chk("mem_rdata", bus.mem_rdata, e_mem_rdata);
            chk("fill_addr", bus.fill_addr, e_fill_addr);
            chk("fill_data", bus.fill_data, e_fill_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit mem, output int e);
        e = -1;
        for (int k = 0; k < 400; k++) begin
            step();
            if ((mem ? bus.mem_done : bus.if_done) === 1'b1) begin
                e = edge_n;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: %s done not seen within 400 cycles", mem ? "mem" : "if");
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, 255));
    endfunction

    task automatic if_proc(input int iters);
        int e;
        for (int it = 0; it < iters; it++) begin
            repeat ($urandom_range(1, 4)) step();
            bus.if_addr = rand_addr();
            bus.if_req  = 1'b1;
            wait_done(1'b0, e);
            bus.if_req  = 1'b0;
        end
    endtask

    task automatic mem_proc(input int iters);
        int e;
        for (int it = 0; it < iters; it++) begin
            repeat ($urandom_range(1, 4)) step();
            bus.mem_we    = 1'($urandom_range(0, 1));
            bus.mem_len   = 2'($urandom_range(0, 3));
            bus.mem_addr  = rand_addr();
            bus.mem_wdata = $urandom;
            bus.mem_req   = 1'b1;
            wait_done(1'b1, e);
            bus.mem_req   = 1'b0;
        end
    endtask

    // ---------------- directed then random ----------------
    initial begin
        int acc, e, e2, cnt, extra;
        bit md_seen;
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'b00;
        bus.mem_addr = '0; bus.mem_wdata = '0;
        preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
        preload(32'h1002, 8'h10); preload(32'h1003, 8'h00);
        preload(32'h20, 8'hAB);
        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h77); preload(32'h103, 8'h88);
        preload(32'hFFFF_FFFE, 8'h01); preload(32'hFFFF_FFFF, 8'h02);
        preload(32'h0, 8'h03); preload(32'h1, 8'h04);
        for (int i = 0; i < 4; i++) preload(32'h200 + 32'(i), 8'h00);

        repeat (3) step();
        chk("rst_ram", {bus.ram_wr, bus.ram_dout, bus.ram_a}, 64'd0);
        chk("rst_done", {bus.if_done, bus.mem_done, bus.fill_replace}, 64'd0);
        chk("rst_data", {bus.if_data, bus.mem_rdata}, 64'd0);
        chk("rst_fill", {bus.fill_addr, bus.fill_data}, 64'd0);
        rst = 1'b1;
        step();

        // IF word read
        bus.if_addr = 32'h1000; bus.if_req = 1'b1; acc = edge_n + 1;
        wait_done(1'b0, e);
        chk("if_latency", 64'(e - acc), 64'd5);
        chk("if_word", bus.if_data, 64'h0010_0513);
        chk("if_fill", {bus.fill_replace, bus.fill_addr, bus.fill_data}, {1'b1, 32'h1000, 32'h0010_0513});
        bus.if_req = 1'b0;
        step();
        chk("if_pulse_width", {bus.if_done, bus.fill_replace}, 64'd0);

        // Simultaneous IF and MEM byte load: MEM first
        bus.mem_addr = 32'h20; bus.mem_len = 2'b00; bus.mem_we = 1'b0; bus.mem_req = 1'b1;
        bus.if_addr = 32'h1000; bus.if_req = 1'b1; acc = edge_n + 1;
        wait_done(1'b1, e);
        chk("prio_mem_latency", 64'(e - acc), 64'd2);
        chk("prio_mem_rdata", bus.mem_rdata, 64'h0000_00AB);
        chk("prio_if_not_done", bus.if_done, 64'd0);
        bus.mem_req = 1'b0;
        wait_done(1'b0, e2);
        chk("prio_if_done_edge", 64'(e2 - acc), 64'd9);
        bus.if_req = 1'b0;
        step();

        // Half store 0x1234ABCD at 0x100
        bus.mem_addr = 32'h100; bus.mem_len = 2'b01; bus.mem_we = 1'b1;
        bus.mem_wdata = 32'h1234_ABCD; bus.mem_req = 1'b1;
        step();
        chk("st_cycle1", {bus.ram_wr, bus.ram_a, bus.ram_dout}, {1'b1, 32'h100, 8'hCD});
        step();
        chk("st_cycle2", {bus.ram_wr, bus.ram_a, bus.ram_dout}, {1'b1, 32'h101, 8'hAB});
        step();
        chk("st_cycle3", {bus.ram_wr, bus.ram_a, bus.ram_dout, bus.mem_done}, {1'b0, 32'h0, 8'h00, 1'b1});
        bus.mem_req = 1'b0;
        step();
        chk("st_ram_bytes", {tb_rd(32'h100), tb_rd(32'h101), tb_rd(32'h102), tb_rd(32'h103)}, 64'hCDAB_7788);

        // Word read across the address wrap
        bus.mem_addr = 32'hFFFF_FFFE; bus.mem_len = 2'b11; bus.mem_we = 1'b0; bus.mem_req = 1'b1;
        step(); chk("wrap_a0", bus.ram_a, 64'hFFFF_FFFE);
        step(); chk("wrap_a1", bus.ram_a, 64'hFFFF_FFFF);
        step(); chk("wrap_a2", bus.ram_a, 64'h0);
        step(); chk("wrap_a3", bus.ram_a, 64'h1);
        wait_done(1'b1, e);
        chk("wrap_rdata", bus.mem_rdata, 64'h0403_0201);
        bus.mem_req = 1'b0;
        step();

        // Reset during the third byte of a word store
        bus.mem_addr = 32'h200; bus.mem_len = 2'b11; bus.mem_we = 1'b1;
        bus.mem_wdata = 32'hDDCC_BBAA; bus.mem_req = 1'b1;
        md_seen = 0;
        repeat (3) begin step(); md_seen |= bus.mem_done; end
        rst = 1'b0; bus.mem_req = 1'b0;
        step(); md_seen |= bus.mem_done;
        chk("abort_ram_out", {bus.ram_wr, bus.ram_dout, bus.ram_a}, 64'd0);
        chk("abort_done_out", {bus.if_done, bus.mem_done, bus.fill_replace}, 64'd0);
        chk("abort_data_out", {bus.if_data, bus.mem_rdata}, 64'd0);
        chk("abort_fill_out", {bus.fill_addr, bus.fill_data}, 64'd0);
        rst = 1'b1;
        repeat (3) begin step(); md_seen |= bus.mem_done; end
        chk("abort_no_done", md_seen, 64'd0);
        chk("abort_bytes01", {tb_rd(32'h200), tb_rd(32'h201)}, 64'hAABB);
        chk("abort_byte3", tb_rd(32'h203), 64'h00);

        // mem_req held through DONE yields exactly one more transfer
        bus.mem_addr = 32'h20; bus.mem_len = 2'b00; bus.mem_we = 1'b0; bus.mem_req = 1'b1;
        acc = edge_n + 1; cnt = 0; e = 0; e2 = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.mem_done === 1'b1) begin
                cnt++;
                if (cnt == 1) e = edge_n;
                else begin e2 = edge_n; bus.mem_req = 1'b0; break; end
            end
        end
        extra = 0;
        repeat (8) begin step(); if (bus.mem_done === 1'b1) extra++; end
        chk("hold_first_done", 64'(e - acc), 64'd2);
        chk("hold_second_done", 64'(e2 - acc), 64'd6);
        chk("hold_done_count", 64'(cnt + extra), 64'd2);

        // Randomized contention
        fork
            if_proc(120);
            mem_proc(120);
        join
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
